// File: rtl/fetch_decode_if.sv
// Bus between the fetch/decode stage, the program memory and the PC stage.
// The master side is fetch_decode; the slave side is the PC stage / memory.
interface fetch_decode_if #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 11,
  parameter int OFF_W   = 10
);
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               jsr;
  logic               ret;
  logic               preload;
  logic [ADDR_W-1:0]  preload_addr;
  logic [OFF_W-1:0]   relative_addr;
  logic               op_valid;
  logic [3:0]         op_code;
  logic [11:0]        op_arg;
  logic [2:0]         depth;
  logic               fault;

  modport master (
    input  pc, imem_data,
    output imem_addr, jsr, ret, preload, preload_addr, relative_addr,
           op_valid, op_code, op_arg, depth, fault
  );

  modport slave (
    output pc, imem_data,
    input  imem_addr, jsr, ret, preload, preload_addr, relative_addr,
           op_valid, op_code, op_arg, depth, fault
  );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode stage: boots the PC, squashes wrong-path words, decodes
// JSR/RET/JMP into PC-stage strobes and tracks the return-stack depth.
module fetch_decode #(
  parameter int              INSTR_W     = 16,
  parameter int              ADDR_W      = 11,
  parameter int              OFF_W       = 10,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input logic           clock,
  input logic           reset_n,
  fetch_decode_if.master bus
);

  typedef enum logic [1:0] {BOOT, FILL, RUN, HALT} state_t;

  localparam logic [3:0] OP_JSR = 4'hF;
  localparam logic [3:0] OP_RET = 4'hE;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [2:0] MAX_DEPTH = 3'(STACK_DEPTH);

  state_t      state;
  logic        live;
  logic [2:0]  depth_q;
  logic        fault_q;

  logic [3:0]        opcode;
  logic              jsr_c, ret_c, preload_c, op_valid_c, fault_hit;
  logic [ADDR_W-1:0] preload_addr_c;
  logic [OFF_W-1:0]  relative_addr_c;

  assign opcode = bus.imem_data[INSTR_W-1 -: 4];

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    jsr_c           = 1'b0;
    ret_c           = 1'b0;
    preload_c       = 1'b0;
    op_valid_c      = 1'b0;
    fault_hit       = 1'b0;
    preload_addr_c  = '0;
    relative_addr_c = '0;
    unique case (state)
      // Boot load is masked while reset is held so nothing strobes in reset.
      BOOT: if (reset_n) begin
        preload_c      = 1'b1;
        preload_addr_c = BOOT_ADDR;
      end
      RUN: if (live) begin
        unique case (opcode)
          OP_JSR: if (depth_q < MAX_DEPTH) begin
            jsr_c           = 1'b1;
            relative_addr_c = bus.imem_data[OFF_W-1:0];
          end else begin
            fault_hit = 1'b1;
          end
          OP_RET: if (depth_q != 3'd0) ret_c = 1'b1;
                  else                 fault_hit = 1'b1;
          OP_JMP: begin
            preload_c      = 1'b1;
            preload_addr_c = bus.imem_data[ADDR_W-1:0];
          end
          default: op_valid_c = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= BOOT;
      live    <= 1'b0;
      depth_q <= 3'd0;
      fault_q <= 1'b0;
    end else begin
      // The word after any PC redirect is on the wrong path.
      live <= !(jsr_c || ret_c || preload_c);
      unique case (state)
        BOOT: state <= FILL;
        FILL: state <= RUN;
        RUN: begin
          if (fault_hit) begin
            state   <= HALT;
            fault_q <= 1'b1;
          end else if (jsr_c) begin
            depth_q <= depth_q + 3'd1;
          end else if (ret_c) begin
            depth_q <= depth_q - 3'd1;
          end
        end
        HALT: state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.imem_addr     = bus.pc;
  assign bus.jsr           = jsr_c;
  assign bus.ret           = ret_c;
  assign bus.preload       = preload_c;
  assign bus.preload_addr  = preload_addr_c;
  assign bus.relative_addr = relative_addr_c;
  assign bus.op_valid      = op_valid_c;
  assign bus.op_code       = opcode;
  assign bus.op_arg        = bus.imem_data[INSTR_W-5:0];
  assign bus.depth         = depth_q;
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: memory plus a PC-stage/program-flow reference model
// with a return-address queue; directed programs followed by random images.
module tb_fetch_decode;
  localparam int          ADDR_W = 11;
  localparam logic [10:0] BOOT   = 11'h010;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fetch_decode_if #(.INSTR_W(16), .ADDR_W(ADDR_W), .OFF_W(10)) bus ();

  fetch_decode #(
    .INSTR_W(16), .ADDR_W(ADDR_W), .OFF_W(10), .STACK_DEPTH(4), .BOOT_ADDR(BOOT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  logic [15:0] mem [2048];
  always @(posedge clock) bus.imem_data <= mem[bus.imem_addr];

  int total = 0;
  int bad   = 0;

  // Reference model state: program-flow view of the machine.
  int          phase;       // cycles since reset release, saturates at 2
  bit          halted, m_fault, squash;
  logic [10:0] m_pc;
  logic [15:0] flight;      // word the memory is presenting this cycle
  logic [10:0] ret_stack [$];

  bit          e_jsr, e_ret, e_pre, e_op, fault_now;
  logic [9:0]  e_rel;
  logic [10:0] e_paddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict this cycle's outputs and compare at the falling edge.
  task automatic check_phase();
    @(negedge clock);
    {e_jsr, e_ret, e_pre, e_op, fault_now} = '0;
    e_rel   = '0;
    e_paddr = '0;
    if (!halted && phase == 0) begin
      e_pre   = 1'b1;
      e_paddr = BOOT;
    end else if (!halted && phase >= 2 && !squash) begin
      case (flight[15:12])
        4'hF: if (ret_stack.size() < 4) begin e_jsr = 1'b1; e_rel = flight[9:0]; end
              else fault_now = 1'b1;
        4'hE: if (ret_stack.size() > 0) e_ret = 1'b1;
              else fault_now = 1'b1;
        4'hD: begin e_pre = 1'b1; e_paddr = flight[10:0]; end
        default: e_op = 1'b1;
      endcase
    end
    chk("imem_addr",     bus.imem_addr,     m_pc);
    chk("jsr",           bus.jsr,           e_jsr);
    chk("ret",           bus.ret,           e_ret);
    chk("preload",       bus.preload,       e_pre);
    chk("preload_addr",  bus.preload_addr,  e_paddr);
    chk("relative_addr", bus.relative_addr, e_rel);
    chk("op_valid",      bus.op_valid,      e_op);
    chk("op_code",       bus.op_code,       flight[15:12]);
    chk("op_arg",        bus.op_arg,        flight[11:0]);
    chk("depth",         bus.depth,         ret_stack.size());
    chk("fault",         bus.fault,         m_fault);
  endtask

  // Apply the predicted strobes as the PC stage would at the rising edge.
  task automatic advance();
    @(posedge clock);
    flight = mem[m_pc];
    if (fault_now) begin halted = 1'b1; m_fault = 1'b1; end
    squash = e_jsr || e_ret || e_pre;
    if (phase < 2) phase++;
    if (e_pre)      m_pc = e_paddr;
    else if (e_jsr) begin
      ret_stack.push_back(m_pc + 11'd1);
      m_pc = m_pc + 11'd1 + 11'(e_rel);
    end
    else if (e_ret) m_pc = ret_stack.pop_back();
    else            m_pc = m_pc + 11'd1;
    #1 bus.pc = m_pc;
  endtask

  task automatic run(input int n);
    repeat (n) begin check_phase(); advance(); end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_jsr",      bus.jsr,      1'b0);
    chk("rst_ret",      bus.ret,      1'b0);
    chk("rst_preload",  bus.preload,  1'b0);
    chk("rst_op_valid", bus.op_valid, 1'b0);
    chk("rst_depth",    bus.depth,    3'd0);
    chk("rst_fault",    bus.fault,    1'b0);
    repeat (2) @(posedge clock);
    flight = mem[m_pc];
    #2 reset_n = 1'b1;
    phase   = 0;
    halted  = 1'b0;
    m_fault = 1'b0;
    squash  = 1'b0;
    ret_stack.delete();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[11'h010] = 16'h1234;
    mem[11'h011] = 16'h2000;
    mem[11'h012] = 16'hD100;   // JMP 0x100
    mem[11'h013] = 16'hF001;   // dead slot, JSR word
    mem[11'h100] = 16'hD020;   // JMP 0x020
    mem[11'h101] = 16'h6666;
    mem[11'h020] = 16'hF005;   // JSR +5 -> 0x027, returns to 0x022
    mem[11'h021] = 16'hF3FF;
    mem[11'h027] = 16'h3111;
    mem[11'h028] = 16'hE000;   // RET
    mem[11'h029] = 16'hF000;
    mem[11'h022] = 16'h4000;
    mem[11'h023] = 16'hD040;   // JMP 0x040
    mem[11'h024] = 16'hE000;
    for (int a = 'h40; a <= 'h48; a += 2) mem[a] = 16'hF000;  // nested calls
    for (int a = 'h49; a < 'h60; a++) mem[a] = 16'h5000 + 16'(a);
    for (int a = 'h41; a < 'h48; a += 2) mem[a] = 16'h7000;

    bus.pc = '0;
    m_pc   = '0;
    do_reset();

    // Boot sequence
    check_phase();
    chk("boot_preload", bus.preload, 1'b1);
    chk("boot_addr",    bus.preload_addr, 11'h010);
    advance();
    check_phase();
    chk("fill_quiet", {bus.jsr, bus.ret, bus.preload, bus.op_valid}, 4'b0000);
    advance();
    check_phase();
    chk("boot_op", {bus.op_valid, bus.op_code, bus.op_arg}, {1'b1, 16'h1234});
    advance();
    run(1);
    check_phase();                                  // JMP 0x100
    chk("jmp_addr", {bus.preload, bus.preload_addr}, {1'b1, 11'h100});
    advance();
    check_phase();                                  // squashed JSR word
    chk("jmp_squash", {bus.jsr, bus.depth}, {1'b0, 3'd0});
    advance();
    run(2);
    check_phase();                                  // JSR 5 at 0x020
    chk("call", {bus.jsr, bus.relative_addr, bus.depth}, {1'b1, 10'd5, 3'd0});
    advance();
    check_phase();
    chk("call_depth", {bus.jsr, bus.depth}, {1'b0, 3'd1});
    advance();
    run(1);
    check_phase();                                  // RET
    chk("ret", {bus.ret, bus.depth}, {1'b1, 3'd1});
    advance();
    check_phase();
    chk("ret_depth", bus.depth, 3'd0);
    advance();
    check_phase();                                  // resumed at 0x022
    chk("resume", {bus.op_valid, bus.op_code}, {1'b1, 4'h4});
    advance();
    run(10);
    check_phase();                                  // 5th JSR
    chk("ovf", {bus.jsr, bus.depth, bus.fault}, {1'b0, 3'd4, 1'b0});
    advance();
    check_phase();
    chk("ovf_halt", {bus.fault, bus.op_valid}, {1'b1, 1'b0});
    advance();
    run(8);

    // Underflow
    mem[11'h010] = 16'hE000;
    do_reset();
    run(2);
    check_phase();
    chk("unf_ret", {bus.ret, bus.fault}, {1'b0, 1'b0});
    advance();
    check_phase();
    chk("unf_halt", {bus.fault, bus.op_valid}, {1'b1, 1'b0});
    advance();
    run(5);

    // Asynchronous reset during a jsr cycle, then boot again
    mem[11'h010] = 16'hF002;
    do_reset();
    run(2);
    check_phase();
    chk("pre_rst_jsr", bus.jsr, 1'b1);
    do_reset();
    check_phase();
    chk("reboot", bus.preload, 1'b1);
    advance();
    run(5);

    // Random program images with a reset between each
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
      do_reset();
      run(30 + int'($urandom_range(0, 30)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode stage that sits between program memory and the program counter stage. It forwards the current `pc` to a synchronous program memory and decodes each returned word. It drives the counter's `jsr`/`ret`/`preload`/`relative_addr` controls and passes ordinary instructions downstream on `op_*`. It also mirrors the 4-entry return-address stack depth, so overflow and underflow become a sticky fault instead of being silently ignored.

## Interface
- `INSTR_W`, 16, instruction word width
- `ADDR_W`, 11, program address width
- `OFF_W`, 10, JSR relative offset width
- `STACK_DEPTH`, 4, return-stack entries in the PC stage
- `BOOT_ADDR`, 11'd0, first instruction address after reset

- `clock` in 1: single clock, all state updates on posedge
- `reset_n` in 1: asynchronous, active-low reset
- `pc` in ADDR_W: current program counter from the PC stage
- `imem_addr` out ADDR_W: program memory read address, combinational copy of `pc`
- `imem_data` in INSTR_W: program memory read data, one cycle after the address
- `jsr` out 1: call request to the PC stage
- `ret` out 1: return request to the PC stage
- `preload` out 1: absolute jump or boot load request
- `preload_addr` out ADDR_W: jump target
- `relative_addr` out OFF_W: JSR offset field, passed unmodified
- `op_valid` out 1: `op_code`/`op_arg` hold a non-control instruction this cycle
- `op_code` out 4: `imem_data[15:12]`
- `op_arg` out 12: `imem_data[11:0]`
- `depth` out 3: mirrored call depth, 0..STACK_DEPTH
- `fault` out 1: sticky stack overflow/underflow

## Operation
- Encoding by opcode `[15:12]`:
  - 4'hF: JSR, offset in `[9:0]`
  - 4'hE: RET
  - 4'hD: JMP, target in `[10:0]`
  - all other opcodes: ordinary instructions, sent out on `op_*`
- FSM states:
  - BOOT: assert `preload`=1 with `preload_addr`=BOOT_ADDR for exactly 1 cycle, then go to FILL.
  - FILL: 1 cycle, all controls 0, `op_valid`=0. The word in flight is stale and is discarded. Then go to RUN.
  - RUN: decode `imem_data` whenever the `live` flag is 1.
  - HALT: entered on fault. All controls 0, `op_valid`=0. Only reset exits HALT.
- `live` flag:
  - Cleared in the cycle after any asserted `jsr`, `ret` or `preload`, to squash the wrong-path word.
  - Set otherwise.
  - A squashed word drives nothing and does not change `depth`.
- Control decode in RUN with `live`=1 (combinational from `imem_data`, state and `depth`):
  - JSR with `depth`<STACK_DEPTH: `jsr`=1, `relative_addr`=`[9:0]`, `depth`+1 at the edge.
  - JSR with `depth`==STACK_DEPTH: no `jsr`; `fault`←1 and go to HALT.
  - RET with `depth`>0: `ret`=1, `depth`−1 at the edge.
  - RET with `depth`==0: no `ret`; `fault`←1 and go to HALT.
  - JMP: `preload`=1, `preload_addr`=`[10:0]`. `depth` is unchanged.
  - Any other opcode: `op_valid`=1.
- At most one of `jsr`/`ret`/`preload` is asserted in any cycle.
- Program-flow semantics (decided): for JSR at address A, the target is A+2+offset and the return resumes at A+2. The word at A+1 is a dead slot and is never executed. The same dead-slot rule applies after JMP.
- `relative_addr` and `preload_addr` hold 0 whenever their strobe is 0.

## Timing
- Reset values (asynchronous):
  - state=BOOT, `live`=0, `depth`=0, `fault`=0
  - `jsr`/`ret`/`op_valid`=0
  - `preload`=0 while `reset_n`=0; asserted in the first cycle after release
- Memory contract: `imem_addr` sampled at edge n gives `imem_data` valid during cycle n+1.
- Decode latency is 0 cycles from `imem_data`. Control outputs must settle before the edge at which the PC stage samples them.
- Boot sequence: first `op_valid` or control appears 3 cycles after `reset_n` rises (BOOT, FILL, then word at BOOT_ADDR).
- `reset_n` asserted mid-run: return to BOOT immediately and drop any in-progress strobe.
- `fault` rises at the edge that ends the faulting cycle and stays high until reset.

## Test plan
- Boot: release reset with BOOT_ADDR=0x010 and memory at 0x010 = 0x1234 → `preload`=1 in cycle 1, nothing in cycle 2, `op_valid`=1 with `op_code`=1 and `op_arg`=0x234 in cycle 3.
- Call/return: JSR 0x005 at 0x020 → `jsr`=1 with `relative_addr`=5 and `depth` 0→1. Word at 0x021 is squashed. A later RET gives `ret`=1 and `depth` 1→0. Execution resumes at 0x022.
- Overflow: 4 nested JSRs then a 5th → `depth`=4 and no 5th `jsr`. `fault`=1 and HALT: `op_valid` stays 0 with ordinary words still arriving.
- Underflow: RET with `depth`=0 → `ret`=0, `fault`=1, all outputs quiet until reset.
- JMP squash: JMP 0x100 immediately followed by a JSR word → `preload`=1 with `preload_addr`=0x100. The following JSR produces no `jsr` and `depth` is unchanged.
- Async reset: assert `reset_n`=0 during a `jsr` cycle → `jsr`, `depth` and `fault` go to 0 without waiting for a clock edge. The boot sequence repeats on release.
